// File: rtl/huffman_pkg.sv
// Shared Huffman codec constants and the decoder state encoding.
package huffman_pkg;

    localparam int SYM_W   = 8;
    localparam int MAX_LEN = 12;
    localparam int NSYM    = 256;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 9;

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        DECODE,
        OUT,
        ERR
    } state_t;

endpackage

// File: rtl/huffman_canon_table.sv
// Canonical Huffman length table: per-length code counts, first codes and
// symbol bases, plus the one-length-per-cycle build sequence that derives
// first/base from the counts and detects an oversubscribed table.
module huffman_canon_table
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = huffman_pkg::MAX_LEN,
    parameter int NSYM    = huffman_pkg::NSYM
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 len_we,
    input  logic [LEN_W-1:0]     len_idx,
    input  logic [CNT_W-1:0]     len_cnt,
    input  logic                 build_start,
    output logic                 build_done,
    output logic                 build_err,
    input  logic [LEN_W-1:0]     q_len,
    output logic [MAX_LEN:0]     q_first,
    output logic [CNT_W-1:0]     q_cnt,
    output logic [CNT_W-1:0]     q_base
);

    localparam int FW = MAX_LEN + 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    // Index 0 is never written and stays zero, seeding the recurrence.
    logic [CNT_W-1:0] cnt_q   [0:MAX_LEN];
    logic [CNT_W-1:0] cnt_d   [0:MAX_LEN];
    logic [FW-1:0]    first_q [0:MAX_LEN];
    logic [FW-1:0]    first_d [0:MAX_LEN];
    logic [CNT_W-1:0] base_q  [0:MAX_LEN];
    logic [CNT_W-1:0] base_d  [0:MAX_LEN];
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] step_q, step_d;

    logic [LEN_W-1:0] prev_idx;
    logic [15:0]      new_first;
    logic [15:0]      new_base;
    logic             over_code;
    logic             over_sym;

    // Build step for length step_q using the already-built length below it.
    always_comb begin
        prev_idx  = (step_q == '0) ? '0 : step_q - LEN_W'(1);
        new_first = (16'(first_q[prev_idx]) + 16'(cnt_q[prev_idx])) << 1;
        new_base  = 16'(base_q[prev_idx]) + 16'(cnt_q[prev_idx]);
        over_code = (new_first + 16'(cnt_q[step_q])) > (16'(1) << step_q);
        over_sym  = (new_base + 16'(cnt_q[step_q])) > 16'(NSYM);
    end

    // Next-state for the tables: clear, build sequencing, or count writes.
    always_comb begin
        cnt_d      = cnt_q;
        first_d    = first_q;
        base_d     = base_q;
        busy_d     = busy_q;
        step_d     = step_q;
        build_done = 1'b0;
        build_err  = 1'b0;
        if (clr) begin
            for (int i = 0; i <= MAX_LEN; i++) begin
                cnt_d[i]   = '0;
                first_d[i] = '0;
                base_d[i]  = '0;
            end
            busy_d = 1'b0;
            step_d = '0;
        end else if (busy_q) begin
            first_d[step_q] = FW'(new_first);
            base_d[step_q]  = CNT_W'(new_base);
            if (over_code || over_sym) begin
                build_err = 1'b1;
                busy_d    = 1'b0;
                step_d    = '0;
            end else if (step_q == MAX_L) begin
                build_done = 1'b1;
                busy_d     = 1'b0;
                step_d     = '0;
            end else begin
                step_d = step_q + LEN_W'(1);
            end
        end else if (build_start) begin
            busy_d = 1'b1;
            step_d = LEN_W'(1);
        end else if (len_we && (len_idx != '0) && (len_idx <= MAX_L)) begin
            cnt_d[len_idx] = len_cnt;
        end
    end

    // Table registers with asynchronous clear to an empty code book.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= MAX_LEN; i++) begin
                cnt_q[i]   <= '0;
                first_q[i] <= '0;
                base_q[i]  <= '0;
            end
            busy_q <= 1'b0;
            step_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
            base_q  <= base_d;
            busy_q  <= busy_d;
            step_q  <= step_d;
        end
    end

    // Lookup port; lengths outside 1..MAX_LEN read as an empty length.
    always_comb begin
        q_first = '0;
        q_cnt   = '0;
        q_base  = '0;
        if ((q_len != '0) && (q_len <= MAX_L)) begin
            q_first = first_q[q_len];
            q_cnt   = cnt_q[q_len];
            q_base  = base_q[q_len];
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial canonical Huffman decoder: holds the symbol RAM and the decode
// FSM, and uses huffman_canon_table for per-length first/count/base values.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int SYM_W   = huffman_pkg::SYM_W,
    parameter int MAX_LEN = huffman_pkg::MAX_LEN,
    parameter int NSYM    = huffman_pkg::NSYM
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      len_we,
    input  logic [LEN_W-1:0]          len_idx,
    input  logic [CNT_W-1:0]          len_cnt,
    input  logic                      sym_we,
    input  logic [$clog2(NSYM)-1:0]   sym_addr,
    input  logic [SYM_W-1:0]          sym_data,
    input  logic                      cfg_start,
    input  logic                      tbl_clr,
    input  logic                      dec_flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_bit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SYM_W-1:0]          out_sym,
    output logic [LEN_W-1:0]          out_len,
    output logic                      tbl_rdy,
    output logic                      cfg_err,
    output logic                      dec_err
);

    localparam int FW     = MAX_LEN + 1;
    localparam int ADDR_W = $clog2(NSYM);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [MAX_LEN-2:0] code_q, code_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               out_valid_q, out_valid_d;
    logic [SYM_W-1:0]   out_sym_q, out_sym_d;
    logic [LEN_W-1:0]   out_len_q, out_len_d;
    logic               tbl_rdy_q, tbl_rdy_d;
    logic               cfg_err_q, cfg_err_d;
    logic               dec_err_q, dec_err_d;

    logic [SYM_W-1:0]   sym_mem [0:NSYM-1];

    logic               cfg_open;
    logic               build_start;
    logic               build_done;
    logic               build_err;
    logic [MAX_LEN-1:0] code_n;
    logic [LEN_W-1:0]   len_n;
    logic [FW-1:0]      q_first;
    logic [CNT_W-1:0]   q_cnt;
    logic [CNT_W-1:0]   q_base;
    logic [FW-1:0]      diff;
    logic               match;
    logic [ADDR_W-1:0]  rank;

    assign cfg_open    = (state_q == IDLE) && !tbl_clr;
    assign build_start = cfg_open && cfg_start;
    assign code_n      = {code_q, in_bit};
    assign len_n       = len_q + LEN_W'(1);
    assign diff        = {1'b0, code_n} - q_first;
    assign match       = diff < FW'(q_cnt);
    assign rank        = ADDR_W'(FW'(q_base) + diff);
    assign in_ready    = (state_q == DECODE) && !dec_flush && !tbl_clr;

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_len   = out_len_q;
    assign tbl_rdy   = tbl_rdy_q;
    assign cfg_err   = cfg_err_q;
    assign dec_err   = dec_err_q;

    huffman_canon_table #(
        .MAX_LEN (MAX_LEN),
        .NSYM    (NSYM)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (tbl_clr),
        .len_we      (len_we && cfg_open),
        .len_idx     (len_idx),
        .len_cnt     (len_cnt),
        .build_start (build_start),
        .build_done  (build_done),
        .build_err   (build_err),
        .q_len       (len_n),
        .q_first     (q_first),
        .q_cnt       (q_cnt),
        .q_base      (q_base)
    );

    // Symbol RAM, indexed by canonical rank; only writable while idle.
    always_ff @(posedge clk) begin
        if (sym_we && cfg_open) begin
            sym_mem[sym_addr] <= sym_data;
        end
    end

    // Decode FSM next-state; tbl_clr beats everything, dec_flush beats bits.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_len_d   = out_len_q;
        tbl_rdy_d   = tbl_rdy_q;
        cfg_err_d   = cfg_err_q;
        dec_err_d   = dec_err_q;
        if (tbl_clr) begin
            state_d     = IDLE;
            code_d      = '0;
            len_d       = '0;
            out_valid_d = 1'b0;
            tbl_rdy_d   = 1'b0;
            cfg_err_d   = 1'b0;
            dec_err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        state_d = BUILD;
                    end
                end
                BUILD: begin
                    if (build_err) begin
                        cfg_err_d = 1'b1;
                        state_d   = IDLE;
                    end else if (build_done) begin
                        tbl_rdy_d = 1'b1;
                        state_d   = DECODE;
                    end
                end
                DECODE: begin
                    if (dec_flush) begin
                        code_d = '0;
                        len_d  = '0;
                    end else if (in_valid) begin
                        if (match) begin
                            out_sym_d   = sym_mem[rank];
                            out_len_d   = len_n;
                            out_valid_d = 1'b1;
                            code_d      = '0;
                            len_d       = '0;
                            state_d     = OUT;
                        end else if (len_n == MAX_L) begin
                            dec_err_d = 1'b1;
                            code_d    = '0;
                            len_d     = '0;
                            state_d   = ERR;
                        end else begin
                            code_d = code_n[MAX_LEN-2:0];
                            len_d  = len_n;
                        end
                    end
                end
                OUT: begin
                    if (dec_flush || out_ready) begin
                        out_valid_d = 1'b0;
                        code_d      = '0;
                        len_d       = '0;
                        state_d     = DECODE;
                    end
                end
                ERR: begin
                    if (dec_flush) begin
                        code_d  = '0;
                        len_d   = '0;
                        state_d = DECODE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Decoder state registers; reset discards any partial code or output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            code_q      <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_len_q   <= '0;
            tbl_rdy_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            dec_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_len_q   <= out_len_d;
            tbl_rdy_q   <= tbl_rdy_d;
            cfg_err_q   <= cfg_err_d;
            dec_err_q   <= dec_err_d;
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder with a queue scoreboard and monitor.
module tb_huffman_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       len_we = 1'b0;
    logic [3:0] len_idx = '0;
    logic [8:0] len_cnt = '0;
    logic       sym_we = 1'b0;
    logic [7:0] sym_addr = '0;
    logic [7:0] sym_data = '0;
    logic       cfg_start = 1'b0;
    logic       tbl_clr = 1'b0;
    logic       dec_flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_bit = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_sym;
    logic [3:0] out_len;
    logic       tbl_rdy;
    logic       cfg_err;
    logic       dec_err;

    typedef struct packed {
        logic [7:0]  sym;
        logic [3:0]  len;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cycle = 0;

    huffman_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .len_we    (len_we),
        .len_idx   (len_idx),
        .len_cnt   (len_cnt),
        .sym_we    (sym_we),
        .sym_addr  (sym_addr),
        .sym_data  (sym_data),
        .cfg_start (cfg_start),
        .tbl_clr   (tbl_clr),
        .dec_flush (dec_flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bit    (in_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_len   (out_len),
        .tbl_rdy   (tbl_rdy),
        .cfg_err   (cfg_err),
        .dec_err   (dec_err)
    );

    // 10 ns clock and a rising-edge cycle counter used for latency checks.
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cycle = cycle + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_len(input logic [3:0] idx, input logic [8:0] cnt);
        len_we = 1'b1; len_idx = idx; len_cnt = cnt;
        tick();
        len_we = 1'b0;
    endtask

    task automatic write_sym(input logic [7:0] addr, input logic [7:0] data);
        sym_we = 1'b1; sym_addr = addr; sym_data = data;
        tick();
        sym_we = 1'b0;
    endtask

    task automatic build_table();
        int n = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        while (n < 40) begin
            tick();
            n++;
            if (tbl_rdy) break;
        end
        checkOutput("build_cycles", n, 12);
        checkOutput("build_tbl_rdy", tbl_rdy, 1);
        checkOutput("build_cfg_err", cfg_err, 0);
    endtask

    // Offer one bit; when it completes a code the expected symbol is queued
    // with the cycle at which out_valid must first be seen.
    task automatic applyStimulus(input logic b, input logic push,
                                 input logic [7:0] esym, input logic [3:0] elen);
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) checkOutput("bit_accept_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.sym = esym;
            e.len = elen;
            e.cyc = cycle;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard on each new output and checks it is held.
    initial begin
        logic held = 1'b0;
        exp_t cur;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                held = 1'b0;
            end else begin
                if (!held) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("spurious_out", {out_len, out_sym}, 0);
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                        checkOutput("out_sym", out_sym, cur.sym);
                        checkOutput("out_len", out_len, cur.len);
                        checkOutput("out_latency", cycle, cur.cyc);
                    end
                    held = 1'b1;
                end else begin
                    checkOutput("held_sym", out_sym, cur.sym);
                    checkOutput("held_len", out_len, cur.len);
                end
                if (out_ready) held = 1'b0;
            end
        end
    end

    initial begin
        // Reset state
        #2;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_sym", out_sym, 0);
        checkOutput("rst_out_len", out_len, 0);
        checkOutput("rst_tbl_rdy", tbl_rdy, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_dec_err", dec_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Codes 0, 10, 110, 111
        write_len(4'd1, 9'd1);
        write_len(4'd2, 9'd1);
        write_len(4'd3, 9'd2);
        write_sym(8'd0, 8'h61);
        write_sym(8'd1, 8'h62);
        write_sym(8'd2, 8'h63);
        write_sym(8'd3, 8'h64);
        build_table();
        checkOutput("decode_in_ready", in_ready, 1);

        applyStimulus(1'b0, 1'b1, 8'h61, 4'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        applyStimulus(1'b0, 1'b1, 8'h62, 4'd2);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        applyStimulus(1'b1, 1'b1, 8'h64, 4'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        applyStimulus(1'b0, 1'b1, 8'h63, 4'd3);
        tick();
        tick();

        // Backpressure: output held, no bits accepted until handshake
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h61, 4'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_out_sym", out_sym, 8'h61);
            checkOutput("bp_out_valid", out_valid, 1);
        end
        tick();
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        applyStimulus(1'b0, 1'b1, 8'h62, 4'd2);
        tick();
        tick();

        // Flush a partial 11 then decode 10; flush also beats a live bit
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        dec_flush = 1'b1;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        #1;
        checkOutput("flush_in_ready", in_ready, 0);
        tick();
        dec_flush = 1'b0;
        in_valid  = 1'b0;
        #1;
        checkOutput("post_flush_in_ready", in_ready, 1);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        applyStimulus(1'b0, 1'b1, 8'h62, 4'd2);
        tick();
        tick();

        // Asynchronous reset in the middle of a code
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("amid_in_ready", in_ready, 0);
        checkOutput("amid_out_valid", out_valid, 0);
        checkOutput("amid_out_sym", out_sym, 0);
        checkOutput("amid_out_len", out_len, 0);
        checkOutput("amid_tbl_rdy", tbl_rdy, 0);
        checkOutput("amid_sb_empty", exp_q.size(), 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("amid_idle_in_ready", in_ready, 0);

        // Oversubscribed: three codes of length 1
        write_len(4'd1, 9'd3);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        checkOutput("over_cfg_err_early", cfg_err, 0);
        tick();
        checkOutput("over_cfg_err", cfg_err, 1);
        checkOutput("over_tbl_rdy", tbl_rdy, 0);
        tick();
        checkOutput("over_in_ready", in_ready, 0);
        checkOutput("over_tbl_rdy_late", tbl_rdy, 0);

        tbl_clr = 1'b1;
        tick();
        tbl_clr = 1'b0;
        checkOutput("clr_cfg_err", cfg_err, 0);

        // Single code of length 1; twelve ones never match
        write_len(4'd1, 9'd1);
        build_table();
        for (int i = 0; i < 11; i++) applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        checkOutput("len11_dec_err", dec_err, 0);
        applyStimulus(1'b1, 1'b0, 8'h00, 4'd0);
        checkOutput("len12_dec_err", dec_err, 1);
        checkOutput("len12_in_ready", in_ready, 0);
        tick();
        checkOutput("err_in_ready", in_ready, 0);
        dec_flush = 1'b1;
        tick();
        dec_flush = 1'b0;
        #1;
        checkOutput("err_flush_in_ready", in_ready, 1);
        checkOutput("err_flush_dec_err", dec_err, 1);
        applyStimulus(1'b0, 1'b1, 8'h61, 4'd1);
        tick();
        tick();

        checkOutput("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
